sfft_sample_loader: RTL and testbench

//  Upstream feeder for the SFFT pipeline buffer RAM. Accepts a stream of audio samples over a

---
 rtl/sfft_sample_loader.sv | 124 ++++++++++++
 tb/tb_sfft_sample_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfft_sample_loader.sv
// Sample loader for the SFFT buffer RAM.
// Writes each accepted sample at its bit-reversed address and hands the frame to the FFT.
module sfft_sample_loader #(
    parameter int N_LOG2       = 9,
    parameter int SAMPLE_WIDTH = 24,
    parameter int OUT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic [N_LOG2-1:0]       wr_address,
    output logic                    wr_enable,
    output logic [OUT_WIDTH-1:0]    wr_dataReal,
    output logic [OUT_WIDTH-1:0]    wr_dataImag,
    output logic                    frame_ready,
    input  logic                    fft_done,
    output logic [15:0]             drop_count
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [N_LOG2-1:0]      index_q;
    logic [N_LOG2-1:0]      index_d;
    logic [N_LOG2-1:0]      rev_index;
    logic [N_LOG2-1:0]      addr_d;
    logic [OUT_WIDTH-1:0]   data_d;
    logic                   wen_d;
    logic                   ready_d;
    logic                   frame_d;
    logic [15:0]            drop_d;
    logic                   accept;
    logic                   last;

    assign accept = sample_valid && sample_ready;
    assign last   = (index_q == {N_LOG2{1'b1}});

    // Imaginary part of a real audio stream is always zero
    assign wr_dataImag = '0;

    // Mirror the sample index so the FFT sees its input in bit-reversed order
    always_comb begin
        rev_index = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            rev_index[i] = index_q[N_LOG2-1-i];
        end
    end

    // Next state, next index and next registered outputs
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        addr_d  = wr_address;
        data_d  = wr_dataReal;
        wen_d   = 1'b0;
        drop_d  = drop_count;

        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    index_d = index_q + 1'b1;
                    if (last) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = READY;
            end
            READY: begin
                if (fft_done) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if (accept) begin
            wen_d  = 1'b1;
            addr_d = rev_index;
            data_d = OUT_WIDTH'($signed(sample_in));
        end

        if (sample_valid && !sample_ready && (drop_count != 16'hFFFF)) begin
            drop_d = drop_count + 16'd1;
        end

        ready_d = (state_d == LOAD);
        frame_d = (state_d == READY);
    end

    // State, index and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= LOAD;
            index_q      <= '0;
            sample_ready <= 1'b0;
            wr_enable    <= 1'b0;
            wr_address   <= '0;
            wr_dataReal  <= '0;
            frame_ready  <= 1'b0;
            drop_count   <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            sample_ready <= ready_d;
            wr_enable    <= wen_d;
            wr_address   <= addr_d;
            wr_dataReal  <= data_d;
            frame_ready  <= frame_d;
            drop_count   <= drop_d;
        end
    end

endmodule

// File: tb/tb_sfft_sample_loader.sv
// Bench for sfft_sample_loader with an 8-point frame.
// Expected buffer writes are queued at drive time and popped by a write monitor.
module tb_sfft_sample_loader;

    localparam int NL = 3;
    localparam int SW = 24;
    localparam int OW = 32;

    logic          clk;
    logic          reset_n;
    logic [SW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic [NL-1:0] wr_address;
    logic          wr_enable;
    logic [OW-1:0] wr_dataReal;
    logic [OW-1:0] wr_dataImag;
    logic          frame_ready;
    logic          fft_done;
    logic [15:0]   drop_count;

    typedef struct packed {
        logic [NL-1:0] addr;
        logic [OW-1:0] data;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    logic [NL-1:0] m_idx;
    int            compared;
    int            mismatched;

    sfft_sample_loader #(
        .N_LOG2(NL),
        .SAMPLE_WIDTH(SW),
        .OUT_WIDTH(OW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .wr_address(wr_address),
        .wr_enable(wr_enable),
        .wr_dataReal(wr_dataReal),
        .wr_dataImag(wr_dataImag),
        .frame_ready(frame_ready),
        .fft_done(fft_done),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [NL-1:0] br(input logic [NL-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Every write on the bus must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && wr_enable) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write addr=%0d data=%h", wr_address, wr_dataReal);
            end else begin
                e = q.pop_front();
                if (wr_address !== e.addr || wr_dataReal !== e.data || wr_dataImag !== '0) begin
                    mismatched++;
                    $display("FAIL write got addr=%0d re=%h im=%h want addr=%0d re=%h im=0",
                             wr_address, wr_dataReal, wr_dataImag, e.addr, e.data);
                end
            end
        end
    end

    task automatic send(input logic [SW-1:0] s);
        exp_t x;
        compared++;
        if (sample_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL send_ready got=%b want=1", sample_ready);
        end
        sample_valid = 1'b1;
        sample_in    = s;
        x.addr = br(m_idx);
        x.data = {{(OW-SW){s[SW-1]}}, s};
        q.push_back(x);
        m_idx = m_idx + 1'b1;
        @(negedge clk);
    endtask

    task automatic end_frame();
        sample_valid = 1'b0;
        compared++;
        if (sample_ready !== 1'b0 || frame_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL flush got rdy=%b frm=%b want rdy=0 frm=0", sample_ready, frame_ready);
        end
        @(negedge clk);
        compared++;
        if (frame_ready !== 1'b1 || sample_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL frame_ready got frm=%b rdy=%b want frm=1 rdy=0", frame_ready, sample_ready);
        end
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_writes got=%0d want=0", q.size());
        end
    endtask

    task automatic ack_frame();
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        compared++;
        if (frame_ready !== 1'b0 || sample_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ack got frm=%b rdy=%b want frm=0 rdy=1", frame_ready, sample_ready);
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        fft_done     = 1'b0;
        m_idx        = '0;
        repeat (2) @(negedge clk);
        compared++;
        if ({sample_ready, wr_enable, wr_address, wr_dataReal, wr_dataImag,
             frame_ready, drop_count} !== '0) begin
            mismatched++;
            $display("FAIL reset_state got rdy=%b we=%b a=%0d re=%h im=%h frm=%b drop=%0d want all 0",
                     sample_ready, wr_enable, wr_address, wr_dataReal, wr_dataImag,
                     frame_ready, drop_count);
        end
        reset_n = 1'b1;
        #1;
        compared++;
        if (sample_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_before_edge got=%b want=0", sample_ready);
        end
        @(negedge clk);
        compared++;
        if (sample_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_after_edge got=%b want=1", sample_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            send(SW'(i));
            compared++;
            if (wr_enable !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_wen sample=%0d got=%b want=1", i, wr_enable);
            end
        end
        end_frame();
    endtask

    task automatic test_drop_ready();
        sample_valid = 1'b1;
        repeat (5) @(negedge clk);
        sample_valid = 1'b0;
        compared++;
        if (drop_count !== 16'd5) begin
            mismatched++;
            $display("FAIL drop_ready got=%0d want=5", drop_count);
        end
        compared++;
        if (wr_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL drop_no_write got=%b want=0", wr_enable);
        end
        ack_frame();
    endtask

    task automatic test_sign();
        send(24'h800000);
        compared++;
        if (wr_dataReal !== 32'hFF800000 || wr_dataImag !== '0 || wr_address !== 3'd0) begin
            mismatched++;
            $display("FAIL sign_neg got a=%0d re=%h im=%h want a=0 re=ff800000 im=0",
                     wr_address, wr_dataReal, wr_dataImag);
        end
        send(24'h7FFFFF);
        sample_valid = 1'b0;
        compared++;
        if (wr_dataReal !== 32'h007FFFFF || wr_address !== 3'd4) begin
            mismatched++;
            $display("FAIL sign_pos got a=%0d re=%h want a=4 re=007fffff", wr_address, wr_dataReal);
        end
        @(negedge clk);
        compared++;
        if (wr_enable !== 1'b0 || wr_dataReal !== 32'h007FFFFF || wr_address !== 3'd4) begin
            mismatched++;
            $display("FAIL idle_hold got we=%b a=%0d re=%h want we=0 a=4 re=007fffff",
                     wr_enable, wr_address, wr_dataReal);
        end
    endtask

    task automatic test_toggle();
        logic [SW-1:0] v [2];
        v[0] = 24'h000123;
        v[1] = 24'hFFFF00;
        for (int i = 0; i < 2; i++) begin
            send(v[i]);
            sample_valid = 1'b0;
            compared++;
            if (wr_enable !== 1'b1) begin
                mismatched++;
                $display("FAIL toggle_on step=%0d got=%b want=1", i, wr_enable);
            end
            @(negedge clk);
            compared++;
            if (wr_enable !== 1'b0) begin
                mismatched++;
                $display("FAIL toggle_off step=%0d got=%b want=0", i, wr_enable);
            end
        end
    endtask

    task automatic test_done_in_load();
        fft_done = 1'b1;
        send(24'h000005);
        fft_done = 1'b0;
        send(24'h000006);
        send(24'hABCDEF);
        send(24'h000008);
        end_frame();
        ack_frame();
    endtask

    task automatic test_reset_mid();
        send(24'h111111);
        send(24'h222222);
        send(24'h333333);
        sample_valid = 1'b0;
        compared++;
        if (wr_enable !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset_wen got=%b want=1", wr_enable);
        end
        #2;
        reset_n = 1'b0;
        #1;
        compared++;
        if ({sample_ready, wr_enable, wr_address, wr_dataReal, frame_ready, drop_count} !== '0) begin
            mismatched++;
            $display("FAIL async_reset got rdy=%b we=%b a=%0d re=%h frm=%b drop=%0d want all 0",
                     sample_ready, wr_enable, wr_address, wr_dataReal, frame_ready, drop_count);
        end
        q.delete();
        m_idx = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            send(SW'($urandom));
        end
        end_frame();
    endtask

    task automatic test_saturate();
        force dut.drop_count = 16'hFFFD;
        #1;
        release dut.drop_count;
        sample_valid = 1'b1;
        @(negedge clk);
        compared++;
        if (drop_count !== 16'hFFFE) begin
            mismatched++;
            $display("FAIL drop_step got=%h want=fffe", drop_count);
        end
        repeat (3) @(negedge clk);
        sample_valid = 1'b0;
        compared++;
        if (drop_count !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL drop_sat got=%h want=ffff", drop_count);
        end
        @(negedge clk);
        compared++;
        if (drop_count !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL drop_hold got=%h want=ffff", drop_count);
        end
        ack_frame();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_back_to_back();
        test_drop_ready();
        test_sign();
        test_toggle();
        test_done_in_load();
        test_reset_mid();
        test_saturate();
        repeat (2) @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_writes got=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
